// File: rtl/unpacked_serializer_pkg.sv
// Shared types and elaboration helpers for the unpacked-array width down-converter.
package unpacked_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ser_state_e;

  function automatic int beats_f(input int in_num, input int out_num);
    return in_num / out_num;
  endfunction

  // A counter never collapses to zero bits, even when a vector is a single chunk.
  function automatic int cnt_width_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/unpacked_serializer_beat_counter.sv
// Chunk index counter: clears on a new vector load, advances per output beat, wraps after the last.
module serializer_beat_counter #(
  parameter int BEATS = 4,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          is_last
);

  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign is_last = (cnt_reg == LAST);
  assign cnt     = cnt_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc) begin
      cnt_next = is_last ? '0 : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/unpacked_serializer.sv
// Splits each IN_NUM-element vector into IN_NUM/OUT_NUM chunks, lowest index first.
// Define UNPACKED_SERIALIZER_LAST_EN to add the data_out_last port.
module unpacked_serializer
  import unpacked_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 8,
  parameter int OUT_NUM    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_NUM],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [OUT_NUM],
  output logic                  data_out_valid,
  input  logic                  data_out_ready
`ifdef UNPACKED_SERIALIZER_LAST_EN
  ,
  output logic                  data_out_last
`endif
);

  localparam int BEATS = beats_f(IN_NUM, OUT_NUM);
  localparam int CW    = cnt_width_f(BEATS);
  localparam int IW    = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;

  if (IN_NUM % OUT_NUM != 0) begin : g_bad_ratio
    $error("unpacked_serializer: IN_NUM must be a multiple of OUT_NUM");
  end

  ser_state_e            state_reg;
  ser_state_e            state_next;
  logic                  rst_done_reg;
  logic [DATA_WIDTH-1:0] hold_reg [IN_NUM];
  logic [CW-1:0]         cnt;
  logic                  is_last;
  logic                  in_hs;
  logic                  out_hs;

  assign data_out_valid = (state_reg == BUSY);
  assign out_hs         = data_out_valid && data_out_ready;
  // Accept a new vector when empty, or in the same cycle the final chunk retires.
  assign data_in_ready  = rst_done_reg && (!data_out_valid || (is_last && data_out_ready));
  assign in_hs          = data_in_valid && data_in_ready;

`ifdef UNPACKED_SERIALIZER_LAST_EN
  assign data_out_last  = data_out_valid && is_last;
`endif

  always_comb begin
    state_next = state_reg;
    if (in_hs) begin
      state_next = BUSY;
    end else if (out_hs && is_last) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      rst_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rst_done_reg <= 1'b1;
    end
  end

  serializer_beat_counter #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_beat_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (out_hs),
    .clr     (in_hs),
    .cnt     (cnt),
    .is_last (is_last)
  );

  for (genvar gi = 0; gi < IN_NUM; gi++) begin : g_hold
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_reg[gi] <= '0;
      end else if (in_hs) begin
        hold_reg[gi] <= data_in[gi];
      end
    end
  end

  for (genvar gi = 0; gi < OUT_NUM; gi++) begin : g_out_mux
    logic [IW-1:0] sel_idx;
    assign sel_idx      = IW'(int'(cnt) * OUT_NUM + gi);
    assign data_out[gi] = hold_reg[sel_idx];
  end

endmodule
